// File: rtl/axis_weight_scheduler_if.sv
// rtl/axis_weight_scheduler_if.sv - stream handshake bundle (tdata/tvalid/tready/tlast)
interface axis_weight_scheduler_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_weight_scheduler.sv
// rtl/axis_weight_scheduler.sv - per-packet weight sequencer in front of a stream multiplier
module axis_weight_scheduler #(
    parameter int SDATA_WIDTH  = 128,
    parameter int WEIGHT_WIDTH = 8,
    parameter int NUM_WEIGHTS  = 16,
    parameter int IDX_WIDTH    = 4
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      cfg_wr_en,
    input  logic [IDX_WIDTH-1:0]      cfg_addr,
    input  logic [WEIGHT_WIDTH:0]     cfg_wdata,
    input  logic [IDX_WIDTH:0]        cfg_num,
    input  logic                      enable,
    axis_weight_scheduler_if.slave    s_axis,
    axis_weight_scheduler_if.master   m_axis,
    output logic [WEIGHT_WIDTH:0]     bWeight,
    output logic [IDX_WIDTH-1:0]      weight_idx,
    output logic                      busy
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    localparam logic [IDX_WIDTH:0]   NUM_MAX = (IDX_WIDTH+1)'(NUM_WEIGHTS);
    localparam logic [IDX_WIDTH:0]   ONE_NUM = {{IDX_WIDTH{1'b0}}, 1'b1};
    localparam logic [IDX_WIDTH-1:0] ONE_IDX = {{(IDX_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state, state_n;
    logic [WEIGHT_WIDTH:0]   wtable [NUM_WEIGHTS];
    logic [IDX_WIDTH:0]      num_q;
    logic                    in_pkt;
    logic                    gate, beat, end_beat;
    logic                    start, advance;
    logic [IDX_WIDTH:0]      last_idx;
    logic [IDX_WIDTH-1:0]    idx_next;
    logic [SDATA_WIDTH-1:0]  pass_data;

    // Data path is pure wiring; only the handshake is gated by state.
    assign gate          = (state == RUN) || (state == DRAIN);
    assign m_axis.tvalid = s_axis.tvalid & gate;
    assign s_axis.tready = m_axis.tready & gate;
    assign pass_data     = s_axis.tdata;
    assign m_axis.tdata  = pass_data;
    assign m_axis.tlast  = s_axis.tlast;
    assign busy          = (state != IDLE);

    assign beat     = s_axis.tvalid & s_axis.tready;
    assign end_beat = beat & s_axis.tlast;

    // Wrap also covers an index that somehow sits beyond the active range.
    assign last_idx = num_q - ONE_NUM;
    assign idx_next = ({1'b0, weight_idx} >= last_idx) ? '0 : weight_idx + ONE_IDX;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WEIGHTS; i++) wtable[i] <= '0;
        end else if (cfg_wr_en) begin
            wtable[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        advance = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (cfg_num != '0)) begin
                    state_n = LOAD;
                    start   = 1'b1;
                end
            end
            LOAD: state_n = RUN;
            RUN: begin
                if (end_beat) begin
                    advance = 1'b1;
                    state_n = enable ? LOAD : IDLE;
                end else if (!enable && !beat) begin
                    state_n = in_pkt ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                // enable is deliberately ignored here; only the packet end matters.
                if (end_beat) begin
                    advance = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            weight_idx <= '0;
            num_q      <= '0;
            bWeight    <= '0;
            in_pkt     <= 1'b0;
        end else begin
            if (start) begin
                weight_idx <= '0;
                num_q      <= (cfg_num > NUM_MAX) ? NUM_MAX : cfg_num;
            end else if (advance) begin
                weight_idx <= idx_next;
            end
            // Read happens before a same-cycle table write lands.
            if (state == LOAD) bWeight <= wtable[weight_idx];
            if (beat) in_pkt <= ~s_axis.tlast;
        end
    end
endmodule

// File: tb/tb_axis_weight_scheduler.sv
// tb/tb_axis_weight_scheduler.sv - scoreboard bench for axis_weight_scheduler
module tb_axis_weight_scheduler;
    logic        clk;
    logic        rst;
    logic        cfg_wr_en;
    logic [3:0]  cfg_addr;
    logic [8:0]  cfg_wdata;
    logic [4:0]  cfg_num;
    logic        enable;
    logic [8:0]  b_weight;
    logic [3:0]  weight_idx;
    logic        busy;

    axis_weight_scheduler_if #(.DATA_WIDTH(128)) s_axis ();
    axis_weight_scheduler_if #(.DATA_WIDTH(128)) m_axis ();

    axis_weight_scheduler dut (
        .CLK        (clk),
        .reset      (rst),
        .cfg_wr_en  (cfg_wr_en),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_num    (cfg_num),
        .enable     (enable),
        .s_axis     (s_axis),
        .m_axis     (m_axis),
        .bWeight    (b_weight),
        .weight_idx (weight_idx),
        .busy       (busy)
    );

    typedef struct {
        logic [127:0] data;
        logic         last;
        logic [8:0]   wt;
        logic [3:0]   idx;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every beat leaving the block must match the oldest expected beat.
    initial begin
        forever begin
            @(negedge clk);
            if (m_axis.tvalid && m_axis.tready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mon_unexpected_beat: got data %0h expected no beat", m_axis.tdata);
                end else begin
                    mon_e = sbq.pop_front();
                    check("mon_tdata", m_axis.tdata, mon_e.data);
                    check("mon_tlast", m_axis.tlast, mon_e.last);
                    check("mon_bweight", b_weight, mon_e.wt);
                    check("mon_weight_idx", weight_idx, mon_e.idx);
                end
            end
        end
    end

    task automatic drive_beat(input logic [127:0] d, input logic l, input logic [8:0] wt, input logic [3:0] idx);
        exp_t e;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = d;
        s_axis.tlast  = l;
        e.data = d; e.last = l; e.wt = wt; e.idx = idx;
        sbq.push_back(e);
    endtask

    task automatic wait_beat(output int waits);
        waits = 0;
        @(negedge clk);
        while (!s_axis.tready && waits < 64) begin
            waits++;
            @(negedge clk);
        end
        if (!s_axis.tready) check("beat_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic send_beat(input logic [127:0] d, input logic l, input logic [8:0] wt,
                             input logic [3:0] idx, output int waits);
        drive_beat(d, l, wt, idx);
        wait_beat(waits);
    endtask

    task automatic send_pkt(input int n, input logic [127:0] base, input logic [8:0] wt,
                            input logic [3:0] idx, output int first_waits);
        int wb;
        for (int i = 0; i < n; i++) begin
            send_beat(base + 128'(i), (i == n - 1), wt, idx, wb);
            if (i == 0) first_waits = wb;
        end
    endtask

    task automatic go_idle(input string name);
        int cnt;
        enable = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check(name, busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input logic [3:0] a, input logic [8:0] d);
        cfg_wr_en = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(posedge clk);
        #1;
        cfg_wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cfg_wr_en = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_num = '0; enable = 1'b0;
        s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0;
        m_axis.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_bweight", b_weight, 9'h000);
        check("rst_weight_idx", weight_idx, 4'd0);
        check("rst_s_tready", s_axis.tready, 1'b0);
        check("rst_m_tvalid", m_axis.tvalid, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Rotating weights across back-to-back packets
        write_w(4'd0, 9'h040);
        write_w(4'd1, 9'h080);
        write_w(4'd2, 9'h0FF);
        cfg_num = 5'd3;
        enable  = 1'b1;
        send_pkt(4, 128'hA000, 9'h040, 4'd0, w);
        send_pkt(4, 128'hA100, 9'h080, 4'd1, w);
        check("gap_pkt2", w, 1);
        send_pkt(4, 128'hA200, 9'h0FF, 4'd2, w);
        check("gap_pkt3", w, 1);
        send_pkt(4, 128'hA300, 9'h040, 4'd0, w);
        check("gap_pkt4", w, 1);
        go_idle("idle_after_rotate");

        // enable drop mid-packet drains the rest
        enable = 1'b1;
        send_beat(128'hB000, 1'b0, 9'h040, 4'd0, w);
        send_beat(128'hB001, 1'b0, 9'h040, 4'd0, w);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("drain_busy", busy, 1'b1);
        enable = 1'b1;
        send_beat(128'hB002, 1'b0, 9'h040, 4'd0, w);
        send_beat(128'hB003, 1'b1, 9'h040, 4'd0, w);
        check("drain_idle_busy", busy, 1'b0);
        check("drain_weight_idx", weight_idx, 4'd1);
        enable = 1'b0;
        @(posedge clk);
        #1;

        // Downstream backpressure for five cycles mid-packet
        enable = 1'b1;
        send_beat(128'hC000, 1'b0, 9'h040, 4'd0, w);
        send_beat(128'hC001, 1'b0, 9'h040, 4'd0, w);
        m_axis.tready = 1'b0;
        drive_beat(128'hC002, 1'b0, 9'h040, 4'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_s_tready", s_axis.tready, 1'b0);
            check("bp_bweight", b_weight, 9'h040);
            @(posedge clk);
            #1;
        end
        m_axis.tready = 1'b1;
        wait_beat(w);
        send_beat(128'hC003, 1'b1, 9'h040, 4'd0, w);
        go_idle("idle_after_bp");

        // Table writes during LOAD of index 1 and during its packet
        enable = 1'b1;
        send_pkt(2, 128'hD000, 9'h040, 4'd0, w);
        write_w(4'd1, 9'h011);
        send_beat(128'hD100, 1'b0, 9'h080, 4'd1, w);
        cfg_wr_en = 1'b1; cfg_addr = 4'd1; cfg_wdata = 9'h022;
        send_beat(128'hD101, 1'b0, 9'h080, 4'd1, w);
        cfg_wr_en = 1'b0;
        send_beat(128'hD102, 1'b1, 9'h080, 4'd1, w);
        send_pkt(1, 128'hD200, 9'h0FF, 4'd2, w);
        send_pkt(1, 128'hD300, 9'h040, 4'd0, w);
        send_pkt(1, 128'hD400, 9'h022, 4'd1, w);
        go_idle("idle_after_wr");

        // cfg_num = 0 never leaves IDLE
        cfg_num = 5'd0;
        enable  = 1'b1;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 128'hE000;
        repeat (3) @(posedge clk);
        #1;
        check("num0_busy", busy, 1'b0);
        check("num0_s_tready", s_axis.tready, 1'b0);
        check("num0_m_tvalid", m_axis.tvalid, 1'b0);
        s_axis.tvalid = 1'b0;
        enable  = 1'b0;
        cfg_num = 5'd3;
        @(posedge clk);
        #1;

        // Asynchronous reset with beats 3-4 still outstanding
        enable = 1'b1;
        send_beat(128'hF000, 1'b0, 9'h040, 4'd0, w);
        send_beat(128'hF001, 1'b0, 9'h040, 4'd0, w);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 128'hF002;
        #2;
        rst = 1'b1;
        #1;
        check("arst_s_tready", s_axis.tready, 1'b0);
        check("arst_m_tvalid", m_axis.tvalid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_bweight", b_weight, 9'h000);
        check("arst_weight_idx", weight_idx, 4'd0);
        s_axis.tvalid = 1'b0;
        cfg_num = 5'd1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 1'b1);
        check("post_rst_weight_idx", weight_idx, 4'd0);
        check("post_rst_bweight", b_weight, 9'h000);
        send_pkt(1, 128'hF100, 9'h000, 4'd0, w);
        send_pkt(1, 128'hF200, 9'h000, 4'd0, w);
        go_idle("idle_after_rst");

        repeat (3) @(posedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
